// File: rtl/leds_cmd_parser.sv
// UART command parser: decodes A5/index/value/checksum frames into
// four 7-segment digit codes, with inter-byte timeout and error strobe.
module leds_cmd_parser #(
    parameter int CLK_FREQ     = 50,
    parameter int BIT_RATE     = 115200,
    parameter int TIMEOUT_BITS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [27:0] leds_data,
    output logic [3:0]  led_data_valid,
    output logic        frame_err
);

    localparam int LIMIT = (CLK_FREQ * 1000000) / BIT_RATE * TIMEOUT_BITS;
    localparam int CW    = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM_C = CW'(LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        INDEX,
        VALUE,
        CHECK
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [27:0]   leds_q;
    logic [3:0]    valid_q;
    logic          err_q;
    logic [7:0]    index_q;
    logic [7:0]    value_q;
    logic          frame_ok;

    function automatic logic [6:0] seg(input logic [7:0] v);
        case (v)
            8'h00:   seg = 7'h40;
            8'h01:   seg = 7'h79;
            8'h02:   seg = 7'h24;
            8'h03:   seg = 7'h30;
            8'h04:   seg = 7'h19;
            8'h05:   seg = 7'h12;
            8'h06:   seg = 7'h02;
            8'h07:   seg = 7'h78;
            8'h08:   seg = 7'h00;
            8'h09:   seg = 7'h10;
            8'h0A:   seg = 7'h08;
            8'h0B:   seg = 7'h03;
            8'h0C:   seg = 7'h46;
            8'h0D:   seg = 7'h21;
            8'h0E:   seg = 7'h06;
            8'h0F:   seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    endfunction

    always_comb begin
        frame_ok = (rx_data == (8'hA5 ^ index_q ^ value_q))
                && (index_q <= 8'h03)
                && (value_q <= 8'h10);
    end

    // Payload bytes are only consumed after a full frame, so no reset needed.
    always_ff @(posedge clk) begin
        if (rx_valid && state_q == INDEX) index_q <= rx_data;
        if (rx_valid && state_q == VALUE) value_q <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            leds_q  <= {28{1'b1}};
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= '0;
            err_q   <= 1'b0;
            if (rx_valid) begin
                cnt_q <= '0;
                case (state_q)
                    IDLE:  if (rx_data == 8'hA5) state_q <= INDEX;
                    INDEX: state_q <= VALUE;
                    VALUE: state_q <= CHECK;
                    CHECK: begin
                        state_q <= IDLE;
                        if (frame_ok) begin
                            for (int i = 0; i < 4; i++) begin
                                if (index_q[1:0] == 2'(i)) begin
                                    leds_q[7*i +: 7] <= seg(value_q);
                                    valid_q[i]       <= 1'b1;
                                end
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                // Limit reached with no byte: drop the partial frame.
                if (cnt_q == LIM_C) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    err_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign leds_data      = leds_q;
    assign led_data_valid = valid_q;
    assign frame_err      = err_q;

endmodule

// File: tb/tb_leds_cmd_parser.sv
// Directed bench for leds_cmd_parser: table of back-to-back frames
// plus hand sequences for garbage, timeout and reset corner cases.
module tb_leds_cmd_parser;

    localparam int LIMIT = 13020;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [27:0] leds_data;
    logic [3:0]  led_data_valid;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    logic [27:0] c_leds;
    logic [3:0]  c_valid;
    logic        c_err;

    typedef struct {
        logic [7:0] b [4];
        logic [6:0] d [4];
        logic [3:0] v;
        logic       e;
    } vec_t;

    vec_t tbl [10];

    leds_cmd_parser dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .leds_data      (leds_data),
        .led_data_valid (led_data_valid),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [27:0] act,
                         input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic capture();
        @(posedge clk);
        #1;
        c_leds  = leds_data;
        c_valid = led_data_valid;
        c_err   = frame_err;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        capture();
    endtask

    task automatic send_frame(input string name, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3);
        logic [7:0] bs [4];
        bs = '{b0, b1, b2, b3};
        for (int i = 0; i < 4; i++) begin
            send_byte(bs[i]);
            if (i < 3) begin
                check({name, " mid valid"}, 28'(c_valid), 28'h0);
                check({name, " mid err"}, 28'(c_err), 28'h0);
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rx_valid = 1'b0;
        capture();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            capture();
            check("reset leds", c_leds, {28{1'b1}});
            check("reset valid", 28'(c_valid), 28'h0);
            check("reset err", 28'(c_err), 28'h0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{'{8'hA5, 8'h02, 8'h05, 8'hA2},
                   '{7'h7F, 7'h7F, 7'h12, 7'h7F}, 4'b0100, 1'b0};
        tbl[1] = '{'{8'hA5, 8'h00, 8'h08, 8'hAD},
                   '{7'h00, 7'h7F, 7'h12, 7'h7F}, 4'b0001, 1'b0};
        tbl[2] = '{'{8'hA5, 8'h00, 8'h10, 8'hB5},
                   '{7'h7F, 7'h7F, 7'h12, 7'h7F}, 4'b0001, 1'b0};
        tbl[3] = '{'{8'hA5, 8'h01, 8'h03, 8'h00},
                   '{7'h7F, 7'h7F, 7'h12, 7'h7F}, 4'b0000, 1'b1};
        tbl[4] = '{'{8'hA5, 8'h04, 8'h01, 8'hA0},
                   '{7'h7F, 7'h7F, 7'h12, 7'h7F}, 4'b0000, 1'b1};
        tbl[5] = '{'{8'hA5, 8'h00, 8'h11, 8'hB4},
                   '{7'h7F, 7'h7F, 7'h12, 7'h7F}, 4'b0000, 1'b1};
        tbl[6] = '{'{8'hA5, 8'h03, 8'h0F, 8'hA9},
                   '{7'h7F, 7'h7F, 7'h12, 7'h0E}, 4'b1000, 1'b0};
        tbl[7] = '{'{8'hA5, 8'h01, 8'h0A, 8'hAE},
                   '{7'h7F, 7'h08, 7'h12, 7'h0E}, 4'b0010, 1'b0};
        tbl[8] = '{'{8'hA5, 8'h01, 8'hA5, 8'h01},
                   '{7'h7F, 7'h08, 7'h12, 7'h0E}, 4'b0000, 1'b1};
        tbl[9] = '{'{8'hA5, 8'h02, 8'h00, 8'hA7},
                   '{7'h7F, 7'h08, 7'h40, 7'h0E}, 4'b0100, 1'b0};

        do_reset(2);

        // Frames are sent back to back with no idle gap.
        for (int k = 0; k < 10; k++) begin
            send_frame($sformatf("vec%0d", k), tbl[k].b[0], tbl[k].b[1],
                       tbl[k].b[2], tbl[k].b[3]);
            check($sformatf("vec%0d leds", k), c_leds,
                  {tbl[k].d[3], tbl[k].d[2], tbl[k].d[1], tbl[k].d[0]});
            check($sformatf("vec%0d valid", k), 28'(c_valid), 28'(tbl[k].v));
            check($sformatf("vec%0d err", k), 28'(c_err), 28'(tbl[k].e));
        end
        idle_cycle();
        check("pulse drop valid", 28'(c_valid), 28'h0);

        // Leading garbage is silently dropped.
        do_reset(1);
        send_byte(8'h00);
        check("garbage 00 err", 28'(c_err), 28'h0);
        send_byte(8'hFF);
        check("garbage FF err", 28'(c_err), 28'h0);
        send_byte(8'h5A);
        check("garbage 5A err", 28'(c_err), 28'h0);
        send_frame("after garbage", 8'hA5, 8'h03, 8'h0F, 8'hA9);
        check("after garbage leds", c_leds, {7'h0E, 7'h7F, 7'h7F, 7'h7F});
        check("after garbage valid", 28'(c_valid), 28'h8);

        // Inter-byte timeout after a partial frame.
        begin
            int pulses;
            int at;
            pulses = 0;
            at     = -1;
            send_byte(8'hA5);
            send_byte(8'h01);
            for (int i = 1; i <= LIMIT + 100; i++) begin
                idle_cycle();
                if (c_err) begin
                    pulses++;
                    if (at < 0) at = i;
                end
            end
            check("timeout pulses", 28'(pulses), 28'd1);
            checks++;
            if (at < LIMIT - 5 || at > LIMIT + 5) begin
                errors++;
                $display("FAIL timeout time: got %0d expected ~%0d", at, LIMIT);
            end
        end
        send_frame("after timeout", 8'hA5, 8'h01, 8'h0A, 8'hAE);
        check("after timeout leds", c_leds, {7'h0E, 7'h7F, 7'h08, 7'h7F});
        check("after timeout valid", 28'(c_valid), 28'h2);

        // A byte arriving on the timeout cycle wins over the timeout.
        begin
            int errs;
            errs = 0;
            send_byte(8'hA5);
            for (int i = 0; i < LIMIT; i++) begin
                idle_cycle();
                if (c_err) errs++;
            end
            send_byte(8'h00);
            if (c_err) errs++;
            send_byte(8'h05);
            if (c_err) errs++;
            send_byte(8'hA0);
            check("coincide no err", 28'(errs), 28'd0);
            check("coincide leds", c_leds, {7'h0E, 7'h7F, 7'h08, 7'h12});
            check("coincide valid", 28'(c_valid), 28'h1);
        end

        // Reset mid-frame abandons the partial frame.
        send_byte(8'hA5);
        send_byte(8'h02);
        do_reset(2);
        send_byte(8'h05);
        check("post reset 05 err", 28'(c_err), 28'h0);
        send_byte(8'hA2);
        check("post reset A2 err", 28'(c_err), 28'h0);
        check("post reset A2 valid", 28'(c_valid), 28'h0);
        check("post reset A2 leds", c_leds, {28{1'b1}});
        send_frame("post reset frame", 8'hA5, 8'h02, 8'h05, 8'hA2);
        check("post reset frame leds", c_leds, {7'h7F, 7'h12, 7'h7F, 7'h7F});
        check("post reset frame valid", 28'(c_valid), 28'h4);
        check("post reset frame err", 28'(c_err), 28'h0);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
